toggle_cover_collector: RTL and testbench

//   Upstream producer for the per-width toggle-coverage reporters. Samples a monitored bus,

---
 rtl/toggle_cover_pkg.sv | 21 ++
 rtl/toggle_cover_collector_if.sv | 13 +
 rtl/toggle_cover_prio_enc.sv | 24 ++
 rtl/toggle_cover_collector.sv | 128 ++++++++++++
 tb/tb_toggle_cover_collector.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/toggle_cover_pkg.sv
// Shared helpers for the toggle-cover collector: point counts, index mapping, direction encoding.
// Pure declarations; no timing or flow control of its own.
package toggle_cover_pkg;

  localparam logic DIR_RISE = 1'b1;
  localparam logic DIR_FALL = 1'b0;

  function automatic int points_of(input int w);
    return 2 * w;
  endfunction

  function automatic int count_w(input int w);
    return $clog2(2 * w + 1);
  endfunction

  // Base plus point number; callers truncate to their index width (no wrap check).
  function automatic logic [63:0] point_to_index(input logic [63:0] base, input logic [63:0] p);
    return base + p;
  endfunction

endpackage

// File: rtl/toggle_cover_collector_if.sv
// Cover-index stream: one index plus direction flag per valid/ready transfer.
// Master holds out_valid/out_index/out_rise stable until out_ready is seen.
interface toggle_cover_collector_if #(
  parameter int INDEX_W = 32
);
  logic               out_valid;
  logic               out_ready;
  logic [INDEX_W-1:0] out_index;
  logic               out_rise;

  modport master (output out_valid, output out_index, output out_rise, input out_ready);
  modport slave  (input out_valid, input out_index, input out_rise, output out_ready);
endinterface

// File: rtl/toggle_cover_prio_enc.sv
// Lowest-set-bit finder, purely combinational (zero latency).
// No flow control; found=0 and idx=0 when no request bit is set.
module toggle_cover_prio_enc #(
  parameter int N = 56,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic          found,
  output logic [IW-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/toggle_cover_collector.sv
// Toggle-cover collector: sticky rise/fall bitmap, each first hit emitted once; 1 edge hit->valid, 1 index/cycle.
// Output register holds under backpressure. Optional TOGGLE_COVER_CLEAR_EN adds a clear input.
module toggle_cover_collector
  import toggle_cover_pkg::*;
#(
  parameter int WIDTH       = 28,
  parameter int COVER_INDEX = 0,
  parameter int INDEX_W     = 32,
  localparam int CNT_W      = count_w(WIDTH)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [WIDTH-1:0]            sig,
`ifdef TOGGLE_COVER_CLEAR_EN
  input  logic                        clear,
`endif
  toggle_cover_collector_if.master    out,
  output logic [CNT_W-1:0]            covered_count,
  output logic                        all_covered
);

  localparam int P  = points_of(WIDTH);
  localparam int PW = (P > 1) ? $clog2(P) : 1;

  logic [WIDTH-1:0]   prev_sig_q, prev_sig_d;
  logic               prev_vld_q, prev_vld_d;
  logic [P-1:0]       covered_q, covered_d;
  logic [P-1:0]       pending_q, pending_d;
  logic               out_valid_q, out_valid_d;
  logic [INDEX_W-1:0] out_index_q, out_index_d;
  logic               out_rise_q, out_rise_d;
  logic [CNT_W-1:0]   covered_count_q, covered_count_d;
  logic               all_covered_q, all_covered_d;

  logic [WIDTH-1:0]   rise_vec, fall_vec;
  logic [P-1:0]       hit_vec, new_hits, drain_req;
  logic [CNT_W-1:0]   new_cnt;
  logic               clear_now;
  logic               pick_found;
  logic [PW-1:0]      pick_idx;

`ifdef TOGGLE_COVER_CLEAR_EN
  assign clear_now = clear;
`else
  assign clear_now = 1'b0;
`endif

  // A clear hides the queue from the drain so nothing new is loaded that edge.
  assign drain_req = clear_now ? '0 : pending_q;

  toggle_cover_prio_enc #(.N(P)) u_prio (
    .req   (drain_req),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    rise_vec = sig & ~prev_sig_q;
    fall_vec = ~sig & prev_sig_q;
    hit_vec  = {fall_vec, rise_vec} & {P{enable & prev_vld_q}};
    new_hits = hit_vec & ~covered_q;

    new_cnt = '0;
    for (int i = 0; i < P; i++) begin
      new_cnt = new_cnt + CNT_W'(new_hits[i]);
    end

    prev_sig_d      = sig;
    prev_vld_d      = 1'b1;
    covered_d       = covered_q | new_hits;
    pending_d       = pending_q | new_hits;
    covered_count_d = covered_count_q + new_cnt;
    out_valid_d     = out_valid_q;
    out_index_d     = out_index_q;
    out_rise_d      = out_rise_q;

    if (!out_valid_q || out.out_ready) begin
      if (pick_found) begin
        out_valid_d         = 1'b1;
        out_index_d         = INDEX_W'(point_to_index(64'(COVER_INDEX), 64'(pick_idx)));
        out_rise_d          = (int'(pick_idx) < WIDTH) ? DIR_RISE : DIR_FALL;
        pending_d[pick_idx] = 1'b0;
      end else begin
        out_valid_d = 1'b0;
      end
    end

    if (clear_now) begin
      covered_d       = '0;
      pending_d       = '0;
      covered_count_d = '0;
    end

    all_covered_d = (covered_count_d == CNT_W'(P));
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      prev_sig_q      <= '0;
      prev_vld_q      <= 1'b0;
      covered_q       <= '0;
      pending_q       <= '0;
      out_valid_q     <= 1'b0;
      out_index_q     <= '0;
      out_rise_q      <= 1'b0;
      covered_count_q <= '0;
      all_covered_q   <= 1'b0;
    end else begin
      prev_sig_q      <= prev_sig_d;
      prev_vld_q      <= prev_vld_d;
      covered_q       <= covered_d;
      pending_q       <= pending_d;
      out_valid_q     <= out_valid_d;
      out_index_q     <= out_index_d;
      out_rise_q      <= out_rise_d;
      covered_count_q <= covered_count_d;
      all_covered_q   <= all_covered_d;
    end
  end

  assign out.out_valid  = out_valid_q;
  assign out.out_index  = out_index_q;
  assign out.out_rise   = out_rise_q;
  assign covered_count  = covered_count_q;
  assign all_covered    = all_covered_q;

endmodule

// File: tb/tb_toggle_cover_collector.sv
// Directed bench for toggle_cover_collector (WIDTH=28, COVER_INDEX=100); clear test only with TOGGLE_COVER_CLEAR_EN.
module tb_toggle_cover_collector;

  localparam int WIDTH   = 28;
  localparam int BASE    = 100;
  localparam int INDEX_W = 32;
  localparam int CNT_W   = $clog2(2 * WIDTH + 1);

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b1;
  logic [WIDTH-1:0] sig = '0;
  logic             clear = 1'b0;
  logic [CNT_W-1:0] covered_count;
  logic             all_covered;

  toggle_cover_collector_if #(.INDEX_W(INDEX_W)) out_if ();

  toggle_cover_collector #(
    .WIDTH       (WIDTH),
    .COVER_INDEX (BASE),
    .INDEX_W     (INDEX_W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .sig           (sig),
`ifdef TOGGLE_COVER_CLEAR_EN
    .clear         (clear),
`endif
    .out           (out_if),
    .covered_count (covered_count),
    .all_covered   (all_covered)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passed = 0;

  // Transfer monitor, sampled on the falling edge.
  int q_idx[$];
  bit q_rise[$];
  int q_cyc[$];
  int cyc = 0;

  always @(negedge clock) begin
    cyc = cyc + 1;
    if (out_if.out_valid && out_if.out_ready) begin
      q_idx.push_back(int'(out_if.out_index));
      q_rise.push_back(out_if.out_rise);
      q_cyc.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic flush_q();
    q_idx.delete();
    q_rise.delete();
    q_cyc.delete();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    sig   = '0;
    run(2);
    reset = 1'b1;
    step();
    flush_q();
  endtask

  task automatic test_reset();
    out_if.out_ready = 1'b1;
    do_reset();
    checks++;
    if (out_if.out_valid !== 1'b0 || out_if.out_index !== 32'd0 || out_if.out_rise !== 1'b0)
      $display("FAIL reset_out: valid=%b idx=%0d rise=%b, required 0/0/0",
               out_if.out_valid, out_if.out_index, out_if.out_rise);
    else passed++;
    checks++;
    if (covered_count !== 6'd0 || all_covered !== 1'b0)
      $display("FAIL reset_cov: count=%0d all=%b, required 0/0", covered_count, all_covered);
    else passed++;
  endtask

  task automatic test_single_rise();
    sig = 28'h8;
    step();
    checks++;
    if (out_if.out_valid !== 1'b0)
      $display("FAIL latency_early: valid=%b, required 0", out_if.out_valid);
    else passed++;
    step();
    checks++;
    if (out_if.out_valid !== 1'b1 || out_if.out_index !== 32'd103 || out_if.out_rise !== 1'b1)
      $display("FAIL single_rise: valid=%b idx=%0d rise=%b, required 1/103/1",
               out_if.out_valid, out_if.out_index, out_if.out_rise);
    else passed++;
    run(4);
    checks++;
    if (q_idx.size() != 1 || q_idx[0] != 103 || q_rise[0] != 1'b1)
      $display("FAIL single_xfer: count=%0d first=%0d, required 1 transfer of 103",
               q_idx.size(), (q_idx.size() > 0) ? q_idx[0] : -1);
    else passed++;
    checks++;
    if (covered_count !== 6'd1)
      $display("FAIL single_count: count=%0d, required 1", covered_count);
    else passed++;
  endtask

  task automatic test_fall_repeat();
    flush_q();
    sig = '0;
    step();
    sig = 28'h8;
    step();
    run(5);
    checks++;
    if (q_idx.size() != 1 || q_idx[0] != 131 || q_rise[0] != 1'b0)
      $display("FAIL fall_repeat: transfers=%0d first=%0d, required 1 transfer of 131 fall",
               q_idx.size(), (q_idx.size() > 0) ? q_idx[0] : -1);
    else passed++;
    checks++;
    if (covered_count !== 6'd2)
      $display("FAIL fall_count: count=%0d, required 2", covered_count);
    else passed++;
  endtask

  task automatic test_drain();
    int bad;
    do_reset();
    sig = '1;
    step();
    run(35);
    bad = 0;
    for (int i = 0; i < q_idx.size(); i++)
      if (q_idx[i] != BASE + i || q_rise[i] != 1'b1 || q_cyc[i] != q_cyc[0] + i) bad++;
    checks++;
    if (q_idx.size() != 28 || bad != 0)
      $display("FAIL drain_seq: transfers=%0d out_of_order=%0d, required 28 consecutive 100..127",
               q_idx.size(), bad);
    else passed++;
  endtask

  task automatic test_backpressure();
    int bad;
    do_reset();
    out_if.out_ready = 1'b0;
    sig = '1;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_if.out_valid !== 1'b1 || out_if.out_index !== 32'd100)
        $display("FAIL bp_hold: cycle=%0d valid=%b idx=%0d, required 1/100",
                 i, out_if.out_valid, out_if.out_index);
      else passed++;
      step();
    end
    out_if.out_ready = 1'b1;
    run(35);
    bad = 0;
    for (int i = 0; i < q_idx.size(); i++)
      if (q_idx[i] != BASE + i) bad++;
    checks++;
    if (q_idx.size() != 28 || bad != 0)
      $display("FAIL bp_drain: transfers=%0d out_of_order=%0d, required 28 ascending",
               q_idx.size(), bad);
    else passed++;
  endtask

  task automatic test_all_toggle();
    int bad;
    do_reset();
    sig = '1;
    step();
    sig = '0;
    step();
    run(70);
    bad = 0;
    for (int i = 0; i < q_idx.size(); i++)
      if (q_idx[i] != BASE + i || q_rise[i] != (i < WIDTH)) bad++;
    checks++;
    if (q_idx.size() != 56 || bad != 0)
      $display("FAIL all_xfers: transfers=%0d bad=%0d, required 56 ascending", q_idx.size(), bad);
    else passed++;
    checks++;
    if (covered_count !== 6'd56 || all_covered !== 1'b1)
      $display("FAIL all_cov: count=%0d all=%b, required 56/1", covered_count, all_covered);
    else passed++;
  endtask

`ifdef TOGGLE_COVER_CLEAR_EN
  task automatic test_clear();
    flush_q();
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++;
    if (covered_count !== 6'd0 || all_covered !== 1'b0)
      $display("FAIL clear_cov: count=%0d all=%b, required 0/0", covered_count, all_covered);
    else passed++;
    sig = 28'h1;
    step();
    run(5);
    checks++;
    if (q_idx.size() != 1 || q_idx[0] != 100 || q_rise[0] != 1'b1 || covered_count !== 6'd1)
      $display("FAIL clear_rehit: transfers=%0d count=%0d, required one 100 rise, count 1",
               q_idx.size(), covered_count);
    else passed++;
  endtask
`endif

  task automatic test_enable();
    do_reset();
    enable = 1'b0;
    sig = 28'h1;
    step();
    sig = '0;
    step();
    sig = 28'h1;
    step();
    enable = 1'b1;
    run(5);
    checks++;
    if (q_idx.size() != 0 || covered_count !== 6'd0)
      $display("FAIL enable_gate: transfers=%0d count=%0d, required 0/0", q_idx.size(), covered_count);
    else passed++;
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    sig = '1;
    step();
    run(10);
    checks++;
    if (q_idx.size() == 0 || q_idx[0] != 100)
      $display("FAIL mid_pre: transfers=%0d, required drain started at 100", q_idx.size());
    else passed++;
    reset = 1'b0;
    step();
    checks++;
    if (out_if.out_valid !== 1'b0 || covered_count !== 6'd0)
      $display("FAIL mid_reset: valid=%b count=%0d, required 0/0", out_if.out_valid, covered_count);
    else passed++;
    reset = 1'b1;
    flush_q();
    run(40);
    checks++;
    if (q_idx.size() != 0)
      $display("FAIL mid_after: transfers=%0d, required 0", q_idx.size());
    else passed++;
  endtask

  initial begin
    out_if.out_ready = 1'b1;
    test_reset();
    test_single_rise();
    test_fall_repeat();
    test_drain();
    test_backpressure();
    test_all_toggle();
`ifdef TOGGLE_COVER_CLEAR_EN
    test_clear();
`endif
    test_enable();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1);
  end

endmodule
